// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared definitions for the MMC3 scanline IRQ unit: register indices, widths, decode helper.
package mmc3_scanline_irq_pkg;

  localparam int CNT_W           = 8;
  localparam int LOW_CNT_W       = 3;
  localparam int A12_LOW_MIN_MAX = 7;

  typedef enum logic [1:0] {
    REG_LATCH   = 2'b00,
    REG_RELOAD  = 2'b01,
    REG_DISABLE = 2'b10,
    REG_ENABLE  = 2'b11
  } reg_sel_e;

  // Register index is {A13, A0}; A14 qualifies the whole $C000-$FFFF window.
  function automatic reg_sel_e decode_reg(input logic a13, input logic a0);
    return reg_sel_e'({a13, a0});
  endfunction

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// CPU/PPU-side signal bundle of the scanline IRQ unit plus its IRQ/debug outputs.
interface mmc3_scanline_irq_if;

  logic        enable;
  logic        cpu_wr_stb;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        ppu_a12;
  logic        irq_req;
  logic [7:0]  counter_dbg;

  modport master (
    output enable, cpu_wr_stb, cpu_addr, cpu_data, ppu_a12,
    input  irq_req, counter_dbg
  );

  modport slave (
    input  enable, cpu_wr_stb, cpu_addr, cpu_data, ppu_a12,
    output irq_req, counter_dbg
  );

endinterface

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// Synchronises raw PPU A12 into the m2 domain and emits one clk_evt per qualified rising edge.
module a12_edge_filter
  import mmc3_scanline_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3
) (
  input  logic m2,
  input  logic rst_n,
  input  logic ppu_a12,
  output logic clk_evt
);

  localparam logic [LOW_CNT_W-1:0] LOW_MIN_C = LOW_CNT_W'(A12_LOW_MIN);
  localparam logic [LOW_CNT_W-1:0] LOW_SAT_C = LOW_CNT_W'(A12_LOW_MIN_MAX);

  logic [1:0]           sync_q, sync_d;
  logic [LOW_CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic                 a3;

  assign a3 = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], ppu_a12};
    low_cnt_d = low_cnt_q;
    if (a3) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_SAT_C) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      low_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  // A nonzero low_cnt implies a3 was low last cycle, so this is a single-cycle rising-edge pulse.
  assign clk_evt = a3 && (low_cnt_q >= LOW_MIN_C);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-compatible scanline IRQ: register decode, reload/decrement counter and sticky IRQ request.
module mmc3_scanline_irq
  import mmc3_scanline_irq_pkg::*;
#(
  parameter int A12_LOW_MIN  = 3,
  parameter bit NEW_IRQ_MODE = 1'b1
) (
  input logic               m2,
  input logic               rst_n,
  mmc3_scanline_irq_if.slave bus
);

  logic [CNT_W-1:0] latch_q, latch_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             reload_pend_q, reload_pend_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_req_q, irq_req_d;

  logic     clk_evt;
  logic     wr;
  reg_sel_e sel;
  logic     old_nz;
  logic     reload_was;
  logic     fire;
  logic     unused_addr;

  assign unused_addr = ^bus.cpu_addr[12:1];

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN)
  ) u_filter (
    .m2      (m2),
    .rst_n   (rst_n),
    .ppu_a12 (bus.ppu_a12),
    .clk_evt (clk_evt)
  );

  // Register writes are applied first so a coincident clock sees the freshly written values.
  always_comb begin
    wr            = bus.cpu_wr_stb && bus.enable && bus.cpu_addr[14];
    sel           = decode_reg(bus.cpu_addr[13], bus.cpu_addr[0]);
    latch_d       = latch_q;
    counter_d     = counter_q;
    reload_pend_d = reload_pend_q;
    irq_en_d      = irq_en_q;
    irq_req_d     = irq_req_q;
    old_nz        = 1'b0;
    reload_was    = 1'b0;
    fire          = 1'b0;

    if (wr) begin
      case (sel)
        REG_LATCH:   latch_d = bus.cpu_data;
        REG_RELOAD: begin
          counter_d     = '0;
          reload_pend_d = 1'b1;
        end
        REG_DISABLE: irq_en_d = 1'b0;
        REG_ENABLE:  irq_en_d = 1'b1;
        default:     ;
      endcase
    end

    if (clk_evt && bus.enable) begin
      old_nz     = (counter_d != '0);
      reload_was = reload_pend_d;
      if (!old_nz || reload_was) begin
        counter_d     = latch_d;
        reload_pend_d = 1'b0;
      end else begin
        counter_d = counter_d - 1'b1;
      end
      fire = (counter_d == '0) && irq_en_d && (NEW_IRQ_MODE || old_nz || reload_was);
    end

    if (fire) begin
      irq_req_d = 1'b1;
    end
    // Acknowledge and mapper-disable both win over a same-cycle set.
    if (!bus.enable || (wr && sel == REG_DISABLE)) begin
      irq_req_d = 1'b0;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q       <= '0;
      counter_q     <= '0;
      reload_pend_q <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_req_q     <= 1'b0;
    end else begin
      latch_q       <= latch_d;
      counter_q     <= counter_d;
      reload_pend_q <= reload_pend_d;
      irq_en_q      <= irq_en_d;
      irq_req_q     <= irq_req_d;
    end
  end

  assign bus.irq_req     = irq_req_q && bus.enable;
  assign bus.counter_dbg = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq: one new-mode and one old-mode instance driven in lockstep.
module tb_mmc3_scanline_irq;

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;
  localparam logic [14:0] A_A001 = 15'h2001;

  logic        m2 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        stb;
  logic [14:0] addr;
  logic [7:0]  data;
  logic        a12;

  mmc3_scanline_irq_if bus_new ();
  mmc3_scanline_irq_if bus_old ();

  assign bus_new.enable     = enable;
  assign bus_new.cpu_wr_stb = stb;
  assign bus_new.cpu_addr   = addr;
  assign bus_new.cpu_data   = data;
  assign bus_new.ppu_a12    = a12;
  assign bus_old.enable     = enable;
  assign bus_old.cpu_wr_stb = stb;
  assign bus_old.cpu_addr   = addr;
  assign bus_old.cpu_data   = data;
  assign bus_old.ppu_a12    = a12;

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .NEW_IRQ_MODE(1'b1)) dut_new (
    .m2(m2), .rst_n(rst_n), .bus(bus_new.slave)
  );
  mmc3_scanline_irq #(.A12_LOW_MIN(3), .NEW_IRQ_MODE(1'b0)) dut_old (
    .m2(m2), .rst_n(rst_n), .bus(bus_old.slave)
  );

  always #5 m2 = ~m2;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       irq_n;
    logic       irq_o;
  } exp_t;

  exp_t       sb[$];
  int         n_err = 0;
  int         n_chk = 0;
  logic [7:0] cur_cnt;
  logic       cur_n;
  logic       cur_o;

  task automatic push(input string tag, input logic [7:0] c, input logic n, input logic o);
    exp_t e;
    e.tag = tag; e.cnt = c; e.irq_n = n; e.irq_o = o;
    sb.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL sb_empty: observed 0 entries expected at least 1");
    end else begin
      e = sb.pop_front();
      n_chk++;
      assert (bus_new.counter_dbg === e.cnt) else begin
        n_err++;
        $error("FAIL %s cnt_new: observed %0d expected %0d", e.tag, bus_new.counter_dbg, e.cnt);
      end
      n_chk++;
      assert (bus_old.counter_dbg === e.cnt) else begin
        n_err++;
        $error("FAIL %s cnt_old: observed %0d expected %0d", e.tag, bus_old.counter_dbg, e.cnt);
      end
      n_chk++;
      assert (bus_new.irq_req === e.irq_n) else begin
        n_err++;
        $error("FAIL %s irq_new: observed %b expected %b", e.tag, bus_new.irq_req, e.irq_n);
      end
      n_chk++;
      assert (bus_old.irq_req === e.irq_o) else begin
        n_err++;
        $error("FAIL %s irq_old: observed %b expected %b", e.tag, bus_old.irq_req, e.irq_o);
      end
      $display("txn %-12s cnt=%0d irq_new=%b irq_old=%b", e.tag, bus_new.counter_dbg,
               bus_new.irq_req, bus_old.irq_req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge m2);
  endtask

  task automatic set_cur(input logic [7:0] c, input logic n, input logic o);
    cur_cnt = c; cur_n = n; cur_o = o;
  endtask

  // One-cycle CPU write; expected state is checked one cycle later.
  task automatic cpu_write(input string tag, input logic [14:0] a, input logic [7:0] d,
                           input logic [7:0] c, input logic n, input logic o);
    addr = a; data = d; stb = 1'b1;
    push(tag, c, n, o);
    wait_neg(1);
    stb = 1'b0;
    check_one();
    set_cur(c, n, o);
  endtask

  // A12 low for low_len cycles then high for high_len (>=3); optional CPU write lands on the clk_evt edge.
  task automatic rise(input string tag, input int low_len, input int high_len,
                      input logic coll, input logic [14:0] ca, input logic [7:0] cd,
                      input logic [7:0] c, input logic n, input logic o);
    a12 = 1'b0;
    wait_neg(low_len);
    a12 = 1'b1;
    push({tag, "_pre"}, cur_cnt, cur_n, cur_o);
    push(tag, c, n, o);
    wait_neg(2);
    check_one();
    if (coll) begin
      addr = ca; data = cd; stb = 1'b1;
    end
    wait_neg(1);
    stb = 1'b0;
    check_one();
    set_cur(c, n, o);
    wait_neg(high_len - 3);
  endtask

  task automatic rise_s(input string tag, input logic [7:0] c, input logic n, input logic o);
    rise(tag, 4, 3, 1'b0, 15'h0, 8'h0, c, n, o);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; stb = 1'b0; addr = '0; data = '0; a12 = 1'b0;
    set_cur(8'd0, 1'b0, 1'b0);
    wait_neg(2);
    push("reset", 8'd0, 1'b0, 1'b0);
    check_one();
    rst_n = 1'b1;
    wait_neg(3);

    // Basic countdown 3,2,1,0 with IRQ on the fourth rise
    cpu_write("t1_latch", A_C000, 8'd3, 8'd0, 1'b0, 1'b0);
    cpu_write("t1_reload", A_C001, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t1_en", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t1_r1", 8'd3, 1'b0, 1'b0);
    rise_s("t1_r2", 8'd2, 1'b0, 1'b0);
    rise_s("t1_r3", 8'd1, 1'b0, 1'b0);
    rise_s("t1_r4", 8'd0, 1'b1, 1'b1);
    cpu_write("t1_e001", A_E001, 8'd0, 8'd0, 1'b1, 1'b1);
    cpu_write("t1_ack", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);

    // A12 low-time filter
    rise("t2_r0", 4, 3, 1'b0, 15'h0, 8'h0, 8'd3, 1'b0, 1'b0);
    rise("t2_gap2", 2, 3, 1'b0, 15'h0, 8'h0, 8'd3, 1'b0, 1'b0);
    rise("t2_gap3", 3, 3, 1'b0, 15'h0, 8'h0, 8'd2, 1'b0, 1'b0);
    rise("t2_long", 3, 10, 1'b0, 15'h0, 8'h0, 8'd1, 1'b0, 1'b0);
    rise("t2_after", 4, 3, 1'b0, 15'h0, 8'h0, 8'd0, 1'b0, 1'b0);

    // latch=0: new mode fires on every rise, old mode only after $C001
    cpu_write("t3_latch0", A_C000, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t3_en", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t3_r1", 8'd0, 1'b1, 1'b0);
    rise_s("t3_r2", 8'd0, 1'b1, 1'b0);
    cpu_write("t3_ack1", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t3_en1", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t3_r3", 8'd0, 1'b1, 1'b0);
    cpu_write("t3_ack2", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t3_en2", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t3_reload", A_C001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t3_r4", 8'd0, 1'b1, 1'b1);
    cpu_write("t3_ack3", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);
    rise("t3_e001", 4, 3, 1'b1, A_E001, 8'h0, 8'd0, 1'b1, 1'b0);

    // Writes coinciding with clk_evt
    cpu_write("t4_ack", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t4_latch5", A_C000, 8'd5, 8'd0, 1'b0, 1'b0);
    rise_s("t4_r1", 8'd5, 1'b0, 1'b0);
    rise_s("t4_r2", 8'd4, 1'b0, 1'b0);
    rise("t4_c001", 4, 3, 1'b1, A_C001, 8'h0, 8'd5, 1'b0, 1'b0);
    rise_s("t4_pend", 8'd4, 1'b0, 1'b0);
    cpu_write("t4_reload", A_C001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise("t4_c000", 4, 3, 1'b1, A_C000, 8'd9, 8'd9, 1'b0, 1'b0);
    cpu_write("t4_latch1", A_C000, 8'd1, 8'd9, 1'b0, 1'b0);
    cpu_write("t4_reload2", A_C001, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t4_en", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t4_r3", 8'd1, 1'b0, 1'b0);
    rise("t4_e000", 4, 3, 1'b1, A_E000, 8'h0, 8'd0, 1'b0, 1'b0);

    // Acknowledge, re-enable, mapper disable
    cpu_write("t5_en", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t5_r1", 8'd1, 1'b0, 1'b0);
    rise_s("t5_r2", 8'd0, 1'b1, 1'b1);
    cpu_write("t5_e001", A_E001, 8'd0, 8'd0, 1'b1, 1'b1);
    cpu_write("t5_e000", A_E000, 8'd0, 8'd0, 1'b0, 1'b0);
    cpu_write("t5_en2", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t5_r3", 8'd1, 1'b0, 1'b0);
    rise_s("t5_r4", 8'd0, 1'b1, 1'b1);
    enable = 1'b0;
    #1;
    push("t5_dis", 8'd0, 1'b0, 1'b0);
    check_one();
    set_cur(8'd0, 1'b0, 1'b0);
    wait_neg(1);
    cpu_write("t5_dis_wr", A_C000, 8'd7, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rise_s("t5_frozen", 8'd0, 1'b0, 1'b0);
    end
    enable = 1'b1;
    wait_neg(1);
    push("t5_reen", 8'd0, 1'b0, 1'b0);
    check_one();
    rise_s("t5_r5", 8'd1, 1'b0, 1'b0);
    cpu_write("t5_a14lo", A_A001, 8'd0, 8'd1, 1'b0, 1'b0);
    rise_s("t5_r6", 8'd0, 1'b1, 1'b1);

    // Asynchronous reset mid-count
    cpu_write("t6_latch7", A_C000, 8'd7, 8'd0, 1'b1, 1'b1);
    rise_s("t6_r7", 8'd7, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    push("t6_rst", 8'd0, 1'b0, 1'b0);
    check_one();
    wait_neg(2);
    push("t6_hold", 8'd0, 1'b0, 1'b0);
    check_one();
    rst_n = 1'b1;
    set_cur(8'd0, 1'b0, 1'b0);
    wait_neg(2);
    rise_s("t6_first", 8'd0, 1'b0, 1'b0);
    cpu_write("t6_en", A_E001, 8'd0, 8'd0, 1'b0, 1'b0);
    rise_s("t6_new", 8'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
